// File: rtl/aes_round_sequencer_pkg.sv
// Shared constants, FSM state type and round-key slicing helper for the
// AES-128 round sequencer.
package aes_pkg;

    localparam int unsigned NR      = 10;
    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned KS_W    = BLOCK_W * (NR + 1);
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRound,
        StDone
    } seq_state_e;

    // Round key r sits at [KS_W-1-BLOCK_W*r -: BLOCK_W]; key 0 is in the MSBs.
    function automatic logic [BLOCK_W-1:0] round_key_slice(
        input logic [KS_W-1:0]  ks,
        input logic [CNT_W-1:0] idx
    );
        logic [KS_W-1:0] shifted;
        shifted = ks << (BLOCK_W * 32'(idx));
        return shifted[KS_W-1 -: BLOCK_W];
    endfunction

endpackage

// File: rtl/aes_round_sequencer_key_mux.sv
// Selects the 128-bit round key for the current round from the held key schedule.
module aes_round_key_mux
    import aes_pkg::*;
(
    input  logic [KS_W-1:0]    ks,
    input  logic [CNT_W-1:0]   round_cnt,
    output logic [BLOCK_W-1:0] round_key
);

    // Pure index decode of the schedule.
    always_comb begin
        round_key = round_key_slice(ks, round_cnt);
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// AES-128 round sequencer: accepts a plaintext and expanded key schedule, applies the
// initial AddRoundKey, then drives an external round datapath one round per cycle and
// returns the ciphertext over a valid/ready handshake.
// Optional AES_SEQ_B2B_EN: accept the next block on the same edge as the output handoff.
module aes_round_sequencer
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    input  logic [KS_W-1:0]    in_ks,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic [BLOCK_W-1:0] round_in,
    output logic [BLOCK_W-1:0] round_key,
    output logic               round_last,
    input  logic [BLOCK_W-1:0] round_out,
    output logic               busy
);

    seq_state_e         fsm_q, fsm_d;
    logic [CNT_W-1:0]   round_cnt_q, round_cnt_d;
    logic [BLOCK_W-1:0] state_reg_q, state_reg_d;
    logic [KS_W-1:0]    ks_reg_q, ks_reg_d;
    logic [BLOCK_W-1:0] sel_key;
    logic               is_last;
    logic               accept;

    aes_round_key_mux u_key_mux (
        .ks        (ks_reg_q),
        .round_cnt (round_cnt_q),
        .round_key (sel_key)
    );

    assign is_last = (round_cnt_q == CNT_W'(NR));
    assign accept  = in_valid && in_ready;

    // Outputs decoded from registered state; datapath-facing signals are zero outside ROUND.
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        round_in   = '0;
        round_key  = '0;
        round_last = 1'b0;
        out_data   = state_reg_q;
        case (fsm_q)
            StIdle: begin
                in_ready = 1'b1;
            end
            StRound: begin
                busy       = 1'b1;
                round_in   = state_reg_q;
                round_key  = sel_key;
                round_last = is_last;
            end
            StDone: begin
                busy      = 1'b1;
                out_valid = 1'b1;
`ifdef AES_SEQ_B2B_EN
                // Ready for the next block exactly when the current one hands off.
                in_ready  = out_ready;
`endif
            end
            default: ;
        endcase
    end

    // Next-state logic; an accept (IDLE, or DONE handoff when enabled) overrides the rest.
    always_comb begin
        fsm_d       = fsm_q;
        round_cnt_d = round_cnt_q;
        state_reg_d = state_reg_q;
        ks_reg_d    = ks_reg_q;
        case (fsm_q)
            StIdle: ;
            StRound: begin
                state_reg_d = round_out;
                if (is_last) begin
                    fsm_d = StDone;
                end else begin
                    round_cnt_d = round_cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    fsm_d = StIdle;
                end
            end
            default: fsm_d = StIdle;
        endcase
        if (accept) begin
            state_reg_d = in_data ^ in_ks[KS_W-1 -: BLOCK_W];
            ks_reg_d    = in_ks;
            round_cnt_d = CNT_W'(1);
            fsm_d       = StRound;
        end
    end

    // State registers; reset aborts any block in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= StIdle;
            round_cnt_q <= '0;
            state_reg_q <= '0;
            ks_reg_q    <= '0;
        end else begin
            fsm_q       <= fsm_d;
            round_cnt_q <= round_cnt_d;
            state_reg_q <= state_reg_d;
            ks_reg_q    <= ks_reg_d;
        end
    end

endmodule
